// File: rtl/mdu_serial.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO; WIDTH+1 edges start->done, start ignored while busy.
// Divider datapath is compiled in only when MDU_DIV_EN is defined; otherwise divides complete as no-ops.
module mdu_serial #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic             mf_sel,
   output logic [WIDTH-1:0] mf_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             dbz
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state;
   logic [CW-1:0]      counter;
   logic [WIDTH-1:0]   ma;
   logic [2*WIDTH-1:0] acc;
   logic               sign_a;
   logic               sign_b;
   logic               is_div;

   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] prod;

   assign a_mag = (op[0] && a_in[WIDTH-1]) ? -a_in : a_in;
   assign b_mag = (op[0] && b_in[WIDTH-1]) ? -b_in : b_in;

   // Multiplier lives in the low half of acc and is shifted out as the product shifts in.
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, ma};
   assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
   assign prod     = (sign_a ^ sign_b) ? -acc : acc;

`ifdef MDU_DIV_EN
   logic [WIDTH-1:0]   mb;
   logic [WIDTH-1:0]   a_raw;
   logic               b_zero;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] div_next;
   logic [WIDTH-1:0]   quo_s;
   logic [WIDTH-1:0]   rem_s;

   // acc = {remainder, quotient/dividend}; trial-subtract the shifted remainder each step.
   assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mb};
   assign div_next = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   assign quo_s    = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_s    = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`endif

   assign mf_data = mf_sel ? hi : lo;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         counter <= '0;
         ma      <= '0;
         acc     <= '0;
         sign_a  <= 1'b0;
         sign_b  <= 1'b0;
         is_div  <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         dbz     <= 1'b0;
`ifdef MDU_DIV_EN
         mb      <= '0;
         a_raw   <= '0;
         b_zero  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  is_div  <= op[1];
                  sign_a  <= op[0] & a_in[WIDTH-1];
                  sign_b  <= op[0] & b_in[WIDTH-1];
                  ma      <= a_mag;
                  acc     <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                  counter <= CW'(WIDTH);
                  dbz     <= 1'b0;
                  busy    <= 1'b1;
`ifdef MDU_DIV_EN
                  mb      <= b_mag;
                  a_raw   <= a_in;
                  b_zero  <= (b_in == '0);
                  state   <= RUN;
`else
                  state   <= op[1] ? FIX : RUN;
`endif
               end else begin
                  if (hi_we) hi <= a_in;
                  if (lo_we) lo <= a_in;
               end
            end
            RUN: begin
               counter <= counter - 1'b1;
`ifdef MDU_DIV_EN
               acc     <= is_div ? div_next : mul_next;
`else
               acc     <= mul_next;
`endif
               if (counter == CW'(1)) state <= FIX;
            end
            FIX: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
               if (!is_div) begin
                  hi <= prod[2*WIDTH-1:WIDTH];
                  lo <= prod[WIDTH-1:0];
               end
`ifdef MDU_DIV_EN
               else if (b_zero) begin
                  lo  <= '1;
                  hi  <= a_raw;
                  dbz <= 1'b1;
               end else begin
                  lo <= quo_s;
                  hi <= rem_s;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mdu_serial.sv
// Directed + random bench for mdu_serial; expected HI/LO/dbz/latency queued at launch, checked at done.
module tb_mdu_serial;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a_in = '0;
   logic [31:0] b_in = '0;
   logic        hi_we = 1'b0;
   logic        lo_we = 1'b0;
   logic        mf_sel = 1'b0;
   logic [31:0] mf_data, hi, lo;
   logic        busy, done, dbz;

   mdu_serial #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
      .hi_we(hi_we), .lo_we(lo_we), .mf_sel(mf_sel), .mf_data(mf_data),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .dbz(dbz)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l, input logic z, input int lat);
      exp_t e;
      e.hi = h; e.lo = l; e.dbz = z; e.lat = lat;
      return e;
   endfunction

   function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sbv;
      logic [63:0]        p;
      logic [31:0]        q, r;
      exp_t               e;
      e = mk(m_hi, m_lo, 1'b0, 1);
      if (o == 2'b00) begin
         p = {32'b0, a} * {32'b0, b};
         e = mk(p[63:32], p[31:0], 1'b0, 33);
      end else if (o == 2'b01) begin
         sa  = {{32{a[31]}}, a};
         sbv = {{32{b[31]}}, b};
         p   = sa * sbv;
         e = mk(p[63:32], p[31:0], 1'b0, 33);
      end else begin
`ifdef MDU_DIV_EN
         if (b == 32'd0) e = mk(a, 32'hFFFF_FFFF, 1'b1, 33);
         else if (o == 2'b10) begin
            q = a / b; r = a % b;
            e = mk(r, q, 1'b0, 33);
         end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e = mk(32'd0, 32'h8000_0000, 1'b0, 33);
         end else begin
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
            e = mk(r, q, 1'b0, 33);
         end
`endif
      end
      return e;
   endfunction

   // Called at #1 after an edge with the DUT idle; returns #1 after the accepting edge.
   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input logic hw);
      sb.push_back(e);
      start = 1'b1; op = o; a_in = a; b_in = b; hi_we = hw; lo_we = hw;
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      chk("busy_after_start", busy, 1'b1);
      chk("dbz_cleared_on_start", dbz, 1'b0);
      chk("done_low_after_start", done, 1'b0);
      chk("hi_held_at_start", hi, m_hi);
      chk("lo_held_at_start", lo, m_lo);
   endtask

   task automatic finish(input string tag);
      exp_t e;
      int   n = 0;
      while (!done && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      e = sb.pop_front();
      chk({tag, "_latency"}, n, e.lat);
      chk({tag, "_hi"}, hi, e.hi);
      chk({tag, "_lo"}, lo, e.lo);
      chk({tag, "_dbz"}, dbz, e.dbz);
      chk({tag, "_busy_low"}, busy, 1'b0);
      mf_sel = 1'b0; #1;
      chk({tag, "_mf_lo"}, mf_data, e.lo);
      mf_sel = 1'b1; #1;
      chk({tag, "_mf_hi"}, mf_data, e.hi);
      m_hi = e.hi;
      m_lo = e.lo;
   endtask

   task automatic done_clears();
      @(posedge clk); #1;
      chk("done_single_cycle", done, 1'b0);
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input exp_t e, input logic hw);
      launch(o, a, b, e, hw);
      finish(tag);
      done_clears();
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int          ndone;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_dbz", dbz, 1'b0);
      chk("rst_mf_data", mf_data, 32'd0);
      rst = 1'b0;

      hi_we = 1'b1; a_in = 32'hCAFE_F00D;
      @(posedge clk); #1;
      hi_we = 1'b0;
      chk("mthi", hi, 32'hCAFE_F00D);
      lo_we = 1'b1; a_in = 32'h0000_1234;
      @(posedge clk); #1;
      lo_we = 1'b0;
      chk("mtlo", lo, 32'h0000_1234);
      chk("mtlo_hi_kept", hi, 32'hCAFE_F00D);
      m_hi = 32'hCAFE_F00D; m_lo = 32'h0000_1234;

      run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33), 1'b0);
      run_op("mult_neg3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, mk(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33), 1'b1);
      run_op("mult_min_sq", 2'b01, 32'h8000_0000, 32'h8000_0000, mk(32'h4000_0000, 32'h0, 1'b0, 33), 1'b0);

      // Back-to-back: second start asserted in the done cycle.
      launch(2'b00, 32'd3, 32'd4, mk(32'd0, 32'd12, 1'b0, 33), 1'b0);
      finish("b2b_first");
      launch(2'b00, 32'd5, 32'd6, mk(32'd0, 32'd30, 1'b0, 33), 1'b0);
      finish("b2b_second");
      done_clears();

      for (int i = 0; i < 6; i++) begin
         ro = 2'($urandom_range(0, 1));
         ra = $urandom; rb = $urandom;
         run_op("rand_mul", ro, ra, rb, model(ro, ra, rb), 1'b0);
      end

`ifdef MDU_DIV_EN
      run_op("div_neg7by2", 2'b11, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33), 1'b0);
      run_op("div_overflow", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'd0, 32'h8000_0000, 1'b0, 33), 1'b0);
      run_op("divu_100by3", 2'b10, 32'd100, 32'd3, mk(32'd1, 32'd33, 1'b0, 33), 1'b0);
      run_op("divu_by_zero", 2'b10, 32'd100, 32'd0, mk(32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 33), 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("dbz_sticky", dbz, 1'b1);
      run_op("multu_after_dbz", 2'b00, 32'd7, 32'd6, mk(32'd0, 32'd42, 1'b0, 33), 1'b0);
      run_op("div_by_zero_raw", 2'b11, 32'hFFFF_FFFB, 32'd0, mk(32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 33), 1'b0);
      for (int i = 0; i < 6; i++) begin
         ro = 2'($urandom_range(2, 3));
         ra = $urandom; rb = $urandom_range(1, 1000);
         if ($urandom_range(0, 1) == 1) rb = $urandom;
         if (rb == 32'd0) rb = 32'd1;
         run_op("rand_div", ro, ra, rb, model(ro, ra, rb), 1'b0);
      end
`else
      lo_we = 1'b1; a_in = 32'h0000_1234;
      @(posedge clk); #1;
      lo_we = 1'b0;
      chk("mtlo_nodiv", lo, 32'h0000_1234);
      m_lo = 32'h0000_1234;
      run_op("divu_nodiv", 2'b10, 32'd100, 32'd3, mk(m_hi, 32'h0000_1234, 1'b0, 1), 1'b0);
      run_op("div_nodiv", 2'b11, 32'hFFFF_FFF9, 32'd0, mk(m_hi, 32'h0000_1234, 1'b0, 1), 1'b0);
`endif

      // Abort: start at E0, ignored start+MTHI at iteration 5, rst at iteration 10.
      start = 1'b1; op = 2'b00; a_in = 32'd9; b_in = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; op = 2'b10; a_in = 32'h0000_DEAD; b_in = 32'd1; hi_we = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0;
      chk("busy_kept_midrun", busy, 1'b1);
      chk("mthi_ignored_busy", hi, m_hi);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      chk("abort_done", done, 1'b0);
      chk("abort_mf_data", mf_data, 32'd0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("abort_no_done", ndone, 0);
      chk("abort_idle", busy, 1'b0);
      m_hi = '0; m_lo = '0;

      run_op("after_abort", 2'b00, 32'd2, 32'd3, mk(32'd0, 32'd6, 1'b0, 33), 1'b0);
      chk("scoreboard_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
